dot_product_accumulator: RTL and testbench

//  Consumes the stream of partial products for one output element of the matrix

---
 rtl/matmul_pkg.sv | 18 +
 rtl/term_counter.sv | 33 +++
 rtl/dot_product_accumulator.sv | 85 ++++++++
 tb/tb_dot_product_accumulator.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared defaults and helpers for the matmul reduction path
package matmul_pkg;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_RES_WIDTH = 37;
   localparam int DEF_DEPTH     = 32;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   // Smallest accumulator width that cannot wrap for depth unsigned width-bit terms
   function automatic int res_width_min(input int width, input int depth);
      return width + $clog2(depth);
   endfunction

endpackage

// File: rtl/term_counter.sv
// rtl/term_counter.sv - mod-DEPTH term index counter with last-term flag
module term_counter #(
   parameter int DEPTH = 32,
   parameter int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   output logic [CW-1:0] count_o,
   output logic          is_last_o
);

   logic [CW-1:0] count_q, count_d;

   assign is_last_o = (count_q == CW'(DEPTH - 1));
   assign count_o   = count_q;

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = is_last_o ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - reduces DEPTH product terms into one widened dot product
module dot_product_accumulator
   import matmul_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int RES_WIDTH = DEF_RES_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int CW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     in_data_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [RES_WIDTH-1:0] out_data_o,
   output logic [CW-1:0]        term_idx_o
);

   if (DEPTH < 1 || RES_WIDTH < res_width_min(WIDTH, DEPTH)) begin : g_bad_params
      $fatal(1, "dot_product_accumulator: DEPTH must be >= 1 and RES_WIDTH >= WIDTH+clog2(DEPTH)");
   end

   logic [RES_WIDTH-1:0] acc_q, acc_d;
   logic [RES_WIDTH-1:0] out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic [RES_WIDTH-1:0] term_ext, sum_base, sum;
   logic                 accept, is_last;
   out_state_e           state;

   // The output register's occupancy is the only state; no separate FSM register.
   assign state      = out_valid_q ? ST_FULL : ST_EMPTY;
   assign in_ready_o = (state == ST_EMPTY) || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;

   term_counter #(.DEPTH(DEPTH), .CW(CW)) u_term_counter (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .en_i      (accept),
      .count_o   (term_idx_o),
      .is_last_o (is_last)
   );

   // First term of a vector restarts the sum, so no clear cycle between vectors.
   always_comb begin
      term_ext               = '0;
      term_ext[WIDTH-1:0]    = in_data_i;
      sum_base               = (term_idx_o == '0) ? '0 : acc_q;
      sum                    = sum_base + term_ext;
   end

   always_comb begin
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         if (is_last) begin
            out_data_d  = sum;
            out_valid_d = 1'b1;
         end else begin
            acc_d = sum;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb/tb_dot_product_accumulator.sv - self-checking bench for DEPTH=4 and DEPTH=1 accumulators
module tb_dot_product_accumulator;

   localparam longint unsigned MASK = (64'd1 << 37) - 64'd1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        out_ready = 1'b0;

   logic        a_in_ready, a_out_valid;
   logic [36:0] a_out_data;
   logic [1:0]  a_term_idx;
   logic        b_in_ready, b_out_valid;
   logic [36:0] b_out_data;
   logic [0:0]  b_term_idx;

   int checks = 0;
   int errors = 0;

   longint unsigned a_q[$];
   longint unsigned a_out = 0;
   bit              a_full = 0;
   longint unsigned b_out = 0;
   bit              b_full = 0;

   always #5 clk = ~clk;

   dot_product_accumulator #(.WIDTH(32), .RES_WIDTH(37), .DEPTH(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
      .in_data_i(in_data), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
      .out_data_o(a_out_data), .term_idx_o(a_term_idx)
   );

   dot_product_accumulator #(.WIDTH(32), .RES_WIDTH(37), .DEPTH(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
      .in_data_i(in_data), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
      .out_data_o(b_out_data), .term_idx_o(b_term_idx)
   );

   function automatic longint unsigned qsum(input longint unsigned q[$]);
      longint unsigned s = 0;
      foreach (q[i]) s += q[i];
      return s & MASK;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("a_out_valid", 64'(a_out_valid), 64'(a_full));
      check("a_out_data",  64'(a_out_data),  a_out);
      check("a_term_idx",  64'(a_term_idx),  64'(a_q.size()));
      check("b_out_valid", 64'(b_out_valid), 64'(b_full));
      check("b_out_data",  64'(b_out_data),  b_out);
      check("b_term_idx",  64'(b_term_idx),  64'd0);
   endtask

   // One clock: drive at negedge, predict handshakes, let the edge pass, compare.
   task automatic cycle(input logic v, input logic [31:0] d, input logic r);
      bit acc_a, acc_b, hs_a, hs_b;
      in_valid = v; in_data = d; out_ready = r;
      #1;
      check("a_in_ready", 64'(a_in_ready), 64'(!a_full || r));
      check("b_in_ready", 64'(b_in_ready), 64'(!b_full || r));
      acc_a = v && (!a_full || r); hs_a = a_full && r;
      acc_b = v && (!b_full || r); hs_b = b_full && r;
      @(posedge clk);
      if (hs_a) a_full = 0;
      if (acc_a) begin
         a_q.push_back(64'(d));
         if (a_q.size() == 4) begin
            a_out = qsum(a_q); a_full = 1; a_q.delete();
         end
      end
      if (hs_b) b_full = 0;
      if (acc_b) begin
         b_out = 64'(d); b_full = 1;
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      a_q.delete(); a_full = 0; a_out = 0; b_full = 0; b_out = 0;
      @(negedge clk);
      rst = 1'b0;
      check("rst_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_out_data",  64'(a_out_data),  64'd0);
      check("rst_term_idx",  64'(a_term_idx),  64'd0);
      check_outputs();
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // 1: four terms back to back
      for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b1);
      check("t1_valid", 64'(a_out_valid), 64'd1);
      check("t1_sum",   64'(a_out_data),  64'd10);
      check("t1_idx",   64'(a_term_idx),  64'd0);
      cycle(1'b0, 32'd0, 1'b1);

      // 2: maximum terms
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'hFFFF_FFFF, 1'b1);
      check("t2_sum", 64'(a_out_data), 64'h3_FFFF_FFFC);
      cycle(1'b0, 32'd0, 1'b1);

      // 3: stall with a held result, then release
      for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'd5, 1'b0);
      check("t3_hold_data",  64'(a_out_data), 64'd10);
      check("t3_hold_ready", 64'(a_in_ready), 64'd0);
      check("t3_hold_idx",   64'(a_term_idx), 64'd0);
      for (int i = 5; i <= 8; i++) cycle(1'b1, 32'(i), 1'b1);
      check("t3_second", 64'(a_out_data), 64'd26);
      cycle(1'b0, 32'd0, 1'b1);

      // 4: DEPTH=1 result replaced in the cycle it is taken
      cycle(1'b1, 32'd7, 1'b1);
      check("t4_first", 64'(b_out_data), 64'd7);
      cycle(1'b1, 32'd9, 1'b1);
      check("t4_valid",  64'(b_out_valid), 64'd1);
      check("t4_second", 64'(b_out_data),  64'd9);
      cycle(1'b0, 32'd0, 1'b1);

      // 5: reset discards a partial vector
      cycle(1'b1, 32'd5, 1'b1);
      cycle(1'b1, 32'd6, 1'b1);
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'd1, 1'b1);
      check("t5_sum", 64'(a_out_data), 64'd4);
      cycle(1'b0, 32'd0, 1'b1);

      // 6: gapped input
      for (int i = 1; i <= 4; i++) begin
         cycle(1'b1, 32'(i), 1'b1);
         cycle(1'b0, 32'hDEAD_BEEF, 1'b1);
      end
      check("t6_sum", 64'(a_out_data), 64'd10);

      // random traffic with random backpressure
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
